// File: rtl/ptr_sync_gray.sv
// ptr_sync_gray: multi-flop synchroniser for a Gray-coded FIFO pointer that
// crosses into the clk domain. Besides the synchronised Gray pointer it gives
// the binary pointer, a one-cycle update strobe with the modular advance, and a
// sticky flag for Gray samples that moved by more than one bit.
//
// Optional build macro: PTR_SYNC_BIN_REG_EN
//   undefined : ptr_bin_out is combinational from ptr_gray_out (latency STAGES)
//   defined   : ptr_bin_out is registered (latency STAGES+1); the update/delta
//               outputs follow the registered value. Gray path and error
//               timing are the same in both builds.
module ptr_sync_gray #(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] ptr_gray_in,
    output logic [WIDTH-1:0] ptr_gray_out,
    output logic [WIDTH-1:0] ptr_bin_out,
    output logic             ptr_update,
    output logic [WIDTH-1:0] ptr_delta,
    output logic             err_multi_bit
);

    // Reject unsupported configurations at elaboration time.
    generate
        if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
            $error("ptr_sync_gray: STAGES must be in 2..4");
        end
        if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
            $error("ptr_sync_gray: WIDTH must be in 2..32");
        end
    endgenerate

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [WIDTH-1:0] sync_q [STAGES];
    logic [WIDTH-1:0] prev_gray_q;
    logic [WIDTH-1:0] prev_bin_q;
    logic             err_q;
    logic             err_d;
    logic [WIDTH-1:0] gray_xor;
    logic             multi_now;
    logic [WIDTH-1:0] bin_diff;

    // Plain flop chain: the first stage samples the asynchronous pointer, the
    // remaining stages only shift. Nothing but the synchronous clear sits
    // between stages, so metastability settling time is not eaten by logic.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= ptr_gray_in;
            for (int s = 1; s < STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign ptr_gray_out = sync_q[STAGES-1];

`ifdef PTR_SYNC_BIN_REG_EN
    logic [WIDTH-1:0] bin_q;

    // Registered binary pointer, one edge behind the synchronised Gray value.
    always_ff @(posedge clk) begin
        if (reset) begin
            bin_q <= '0;
        end else begin
            bin_q <= gray2bin(ptr_gray_out);
        end
    end

    assign ptr_bin_out = bin_q;
`else
    assign ptr_bin_out = gray2bin(ptr_gray_out);
`endif

    // History of the previous cycle's Gray and binary pointers.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_gray_q <= '0;
            prev_bin_q  <= '0;
        end else begin
            prev_gray_q <= ptr_gray_out;
            prev_bin_q  <= ptr_bin_out;
        end
    end

    // Advance reporting and Gray-integrity detection from the history.
    // x & (x-1) is non-zero exactly when x has two or more bits set.
    always_comb begin
        ptr_update = 1'b0;
        ptr_delta  = '0;
        bin_diff   = ptr_bin_out - prev_bin_q;
        gray_xor   = ptr_gray_out ^ prev_gray_q;
        multi_now  = |(gray_xor & (gray_xor - WIDTH'(1)));
        err_d      = err_q | multi_now;
        if (ptr_bin_out != prev_bin_q) begin
            ptr_update = 1'b1;
            ptr_delta  = bin_diff;
        end
    end

    // Sticky error: once a multi-bit step is seen it holds until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    // Flag is visible in the same cycle the bad sample reaches ptr_gray_out.
    assign err_multi_bit = err_q | multi_now;

endmodule
